intersection_phase_scheduler: RTL

//  Sequences a two-way intersection: north-south (NS) and east-west (EW) signal

---
 rtl/intersection_phase_scheduler.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/intersection_phase_scheduler.sv
// Two-way intersection phase sequencer: timed green/yellow/all-red phases with
// demand-held greens and an exclusive all-red pedestrian WALK phase.
module intersection_phase_scheduler #(
    parameter int unsigned TW         = 8,
    parameter int unsigned GREEN_CYC  = 8,
    parameter int unsigned YELLOW_CYC = 3,
    parameter int unsigned ALLRED_CYC = 2,
    parameter int unsigned WALK_CYC   = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ns_car,
    input  logic       ew_car,
    input  logic       ped_req,
    output logic [1:0] ns_light,
    output logic [1:0] ew_light,
    output logic       walk,
    output logic       ped_ack,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        ST_ALLRED = 3'd0,
        ST_NS_GRN = 3'd1,
        ST_NS_YEL = 3'd2,
        ST_EW_GRN = 3'd3,
        ST_EW_YEL = 3'd4,
        ST_WALK   = 3'd5
    } state_e;

    localparam logic [1:0] LIGHT_RED    = 2'b00;
    localparam logic [1:0] LIGHT_YELLOW = 2'b01;
    localparam logic [1:0] LIGHT_GREEN  = 2'b10;

    // Timer reload values: each timed state lasts exactly <state>_CYC cycles
    localparam logic [TW-1:0] GREEN_LD  = TW'(GREEN_CYC - 1);
    localparam logic [TW-1:0] YELLOW_LD = TW'(YELLOW_CYC - 1);
    localparam logic [TW-1:0] ALLRED_LD = TW'(ALLRED_CYC - 1);
    localparam logic [TW-1:0] WALK_LD   = TW'(WALK_CYC - 1);

    localparam logic DIR_NS = 1'b0;
    localparam logic DIR_EW = 1'b1;

    state_e        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          next_dir_q, next_dir_d;
    logic          ped_pending_q, ped_pending_d;
    logic          ped_ack_q, ped_ack_d;
    logic          tmr_done;

    assign tmr_done = (tmr_q == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_ALLRED;
            tmr_q         <= ALLRED_LD;
            next_dir_q    <= DIR_NS;
            ped_pending_q <= 1'b0;
            ped_ack_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            tmr_q         <= tmr_d;
            next_dir_q    <= next_dir_d;
            ped_pending_q <= ped_pending_d;
            ped_ack_q     <= ped_ack_d;
        end
    end

    // Next-state, timer and pedestrian-latch logic
    always_comb begin
        state_d       = state_q;
        tmr_d         = tmr_done ? tmr_q : tmr_q - TW'(1);
        next_dir_d    = next_dir_q;
        ped_pending_d = ped_pending_q | (ped_req & (state_q != ST_WALK));
        ped_ack_d     = 1'b0;

        case (state_q)
            ST_ALLRED: begin
                if (tmr_done) begin
                    if (ped_pending_q) begin
                        state_d       = ST_WALK;
                        tmr_d         = WALK_LD;
                        ped_pending_d = 1'b0;
                        ped_ack_d     = 1'b1;
                    end else begin
                        state_d = (next_dir_q == DIR_EW) ? ST_EW_GRN : ST_NS_GRN;
                        tmr_d   = GREEN_LD;
                    end
                end
            end
            ST_WALK: begin
                if (tmr_done) begin
                    state_d = (next_dir_q == DIR_EW) ? ST_EW_GRN : ST_NS_GRN;
                    tmr_d   = GREEN_LD;
                end
            end
            ST_NS_GRN: begin
                if (tmr_done && (ew_car || ped_pending_q)) begin
                    state_d = ST_NS_YEL;
                    tmr_d   = YELLOW_LD;
                end
            end
            ST_EW_GRN: begin
                if (tmr_done && (ns_car || ped_pending_q)) begin
                    state_d = ST_EW_YEL;
                    tmr_d   = YELLOW_LD;
                end
            end
            ST_NS_YEL: begin
                if (tmr_done) begin
                    state_d    = ST_ALLRED;
                    tmr_d      = ALLRED_LD;
                    next_dir_d = DIR_EW;
                end
            end
            ST_EW_YEL: begin
                if (tmr_done) begin
                    state_d    = ST_ALLRED;
                    tmr_d      = ALLRED_LD;
                    next_dir_d = DIR_NS;
                end
            end
            default: begin
                state_d = ST_ALLRED;
                tmr_d   = ALLRED_LD;
            end
        endcase
    end

    // Moore light decode straight from the state register
    always_comb begin
        ns_light = LIGHT_RED;
        ew_light = LIGHT_RED;
        walk     = 1'b0;
        case (state_q)
            ST_NS_GRN: ns_light = LIGHT_GREEN;
            ST_NS_YEL: ns_light = LIGHT_YELLOW;
            ST_EW_GRN: ew_light = LIGHT_GREEN;
            ST_EW_YEL: ew_light = LIGHT_YELLOW;
            ST_WALK:   walk     = 1'b1;
            default:   ;
        endcase
    end

    assign ped_ack = ped_ack_q;
    assign phase   = state_q;

endmodule
